// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data memory access stage:
// memory opcodes, access FSM states and store lane helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SWL = 6'b101010;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SWR = 6'b101110;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LWL, OP_LW,
                          OP_LBU, OP_LHU, OP_LWR};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
    endfunction

    function automatic logic misaligned(input logic [5:0] op,
                                        input logic [1:0] k);
        return ((op inside {OP_LH, OP_LHU, OP_SH}) && k[0]) ||
               ((op inside {OP_LW, OP_SW}) && (k != 2'd0));
    endfunction

    // Big-endian lanes: bit 3 is bits [31:24], byte offset 0.
    function automatic logic [3:0] store_be(input logic [5:0] op,
                                            input logic [1:0] k);
        logic [3:0] be;
        be = 4'b1111;
        unique case (op)
            OP_SB:   be = 4'b1000 >> k;
            OP_SH:   be = k[1] ? 4'b0011 : 4'b1100;
            OP_SWL:  be = 4'b1111 >> k;
            OP_SWR:  be = 4'b1111 << (~k);
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // ~k equals 3-k for a two-bit offset.
    function automatic logic [31:0] store_lanes(input logic [5:0]  op,
                                                input logic [1:0]  k,
                                                input logic [31:0] rt);
        logic [31:0] d;
        d = 32'h0;
        unique case (op)
            OP_SB:   d = {4{rt[7:0]}};
            OP_SH:   d = {2{rt[15:0]}};
            OP_SW:   d = rt;
            OP_SWL:  d = rt >> {k, 3'b000};
            OP_SWR:  d = rt << {~k, 3'b000};
            default: d = 32'h0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/data_mem_port_load_extend.sv
// Byte/half extraction and extension of a loaded word.
// Ports: word/op/offset in, result out (raw word for LW/LWL/LWR).
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel = word[31:24];
        unique case (offset)
            2'd0: bsel = word[31:24];
            2'd1: bsel = word[23:16];
            2'd2: bsel = word[15:8];
            2'd3: bsel = word[7:0];
        endcase
        hsel = offset[1] ? word[15:0] : word[31:16];
        result = word;
        unique case (op)
            OP_LB:   result = {{24{bsel[7]}}, bsel};
            OP_LBU:  result = {24'h0, bsel};
            OP_LH:   result = {{16{hsel[15]}}, hsel};
            OP_LHU:  result = {16'h0, hsel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// Load/store access stage: alignment check, bus handshake, load result.
// Ports: pipeline side (active/instruction/address/store_data,
// stall/fault/read_valid/read_data) and data memory bus (data_*).
module data_mem_port
    import mips_mem_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_address,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        fault,
    output logic        read_valid,
    output logic [31:0] read_data,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata,
    input  logic        data_waitrequest
);

    state_t      state, state_n;
    logic [5:0]  op, op_q;
    logic [1:0]  k, k_q;
    logic [31:0] wait_cnt;
    logic [31:0] ext;
    logic        is_ld, is_st, is_mem, mis;
    logic        accept, last_wait;
    logic        ld_q, st_q, to_q;
    logic        unused;

    assign op     = instruction[31:26];
    assign k      = mem_address[1:0];
    assign unused = ^instruction[25:0];
    assign is_ld  = is_load(op);
    assign is_st  = is_store(op);
    assign is_mem = is_ld || is_st;
    assign mis    = misaligned(op, k);
    assign accept = (state == IDLE) && active && is_mem && !mis;

    // This wait cycle would bring the counter up to the limit.
    assign last_wait = (WAIT_LIMIT != 0) &&
                       (wait_cnt + 32'd1 == WAIT_LIMIT);

    load_extend u_ext (
        .word   (data_readdata),
        .op     (op_q),
        .offset (k_q),
        .result (ext)
    );

    always_comb begin
        state_n    = state;
        stall      = 1'b0;
        fault      = 1'b0;
        read_valid = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (active && is_mem) begin
                    if (mis) begin
                        fault = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_n = BUS;
                    end
                end
            end
            BUS: begin
                stall      = 1'b1;
                data_read  = ld_q;
                data_write = st_q;
                if (!data_waitrequest || last_wait)
                    state_n = DONE;
            end
            DONE: begin
                fault      = to_q;
                read_valid = ld_q && !to_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // An access caught by reset is dropped silently.
        if (reset) begin
            stall      = 1'b0;
            fault      = 1'b0;
            read_valid = 1'b0;
            data_read  = 1'b0;
            data_write = 1'b0;
            state_n    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wait_cnt        <= 32'd0;
            op_q            <= 6'd0;
            k_q             <= 2'd0;
            ld_q            <= 1'b0;
            st_q            <= 1'b0;
            to_q            <= 1'b0;
            read_data       <= 32'h0;
            data_address    <= 32'h0;
            data_byteenable <= 4'h0;
            data_writedata  <= 32'h0;
        end else begin
            state <= state_n;
            if (accept) begin
                data_address    <= {mem_address[31:2], 2'b00};
                data_byteenable <= store_be(op, k);
                data_writedata  <= store_lanes(op, k, store_data);
                op_q            <= op;
                k_q             <= k;
                ld_q            <= is_ld;
                st_q            <= is_st;
                to_q            <= 1'b0;
                wait_cnt        <= 32'd0;
            end
            if (state == BUS) begin
                if (!data_waitrequest) begin
                    if (ld_q)
                        read_data <= ext;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (last_wait)
                        to_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_port.sv
// Randomized self-checking bench for data_mem_port against a
// lane-level model; two instances (WAIT_LIMIT 255 and 3).
module tb_data_mem_port;

    localparam logic [5:0] LB  = 6'b100000, LH  = 6'b100001;
    localparam logic [5:0] LWL = 6'b100010, LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100, LHU = 6'b100101;
    localparam logic [5:0] LWR = 6'b100110, SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001, SWL = 6'b101010;
    localparam logic [5:0] SW  = 6'b101011, SWR = 6'b101110;
    localparam int LIM0 = 255;
    localparam int LIM1 = 3;

    typedef struct {
        logic        stall, fault, rv, rd, wr, bus, wchk;
        logic [31:0] addr, wd, rdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, active, data_waitrequest;
    logic [31:0] instruction, mem_address, store_data, data_readdata;
    logic [1:0]  stall, fault, rv, drd, dwr;
    logic [31:0] rdata [2];
    logic [31:0] daddr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];

    exp_t        ex [2];
    logic [31:0] last_rd [2];
    logic        chk_en = 1'b0;
    int          pass_cnt = 0, tot_cnt = 0;
    int n_stall [2], n_fault [2], n_rv [2], n_rd [2], n_wr [2];
    logic [31:0] obs_addr [2], obs_wd [2], obs_rv [2];
    logic [3:0]  obs_be [2];
    string       lit_nm;
    logic [31:0] lit_a, lit_e;
    int          lit_seq = 0, lit_done = 0;

    always #5 clk = ~clk;

    data_mem_port #(.WAIT_LIMIT(LIM0)) u0 (
        .clk(clk), .reset(reset), .active(active),
        .instruction(instruction), .mem_address(mem_address),
        .store_data(store_data), .stall(stall[0]), .fault(fault[0]),
        .read_valid(rv[0]), .read_data(rdata[0]),
        .data_address(daddr[0]), .data_read(drd[0]),
        .data_write(dwr[0]), .data_byteenable(be[0]),
        .data_writedata(wdata[0]), .data_readdata(data_readdata),
        .data_waitrequest(data_waitrequest)
    );

    data_mem_port #(.WAIT_LIMIT(LIM1)) u1 (
        .clk(clk), .reset(reset), .active(active),
        .instruction(instruction), .mem_address(mem_address),
        .store_data(store_data), .stall(stall[1]), .fault(fault[1]),
        .read_valid(rv[1]), .read_data(rdata[1]),
        .data_address(daddr[1]), .data_read(drd[1]),
        .data_write(dwr[1]), .data_byteenable(be[1]),
        .data_writedata(wdata[1]), .data_readdata(data_readdata),
        .data_waitrequest(data_waitrequest)
    );

    function automatic logic [7:0] lg(input logic [31:0] w, input int i);
        return w[31-8*i -: 8];
    endfunction

    function automatic logic [31:0] lp(input logic [31:0] w, input int i,
                                       input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[31-8*i -: 8] = b;
        return r;
    endfunction

    function automatic logic is_ld_f(input logic [5:0] op);
        return op inside {LB, LH, LWL, LW, LBU, LHU, LWR};
    endfunction

    function automatic logic is_st_f(input logic [5:0] op);
        return op inside {SB, SH, SWL, SW, SWR};
    endfunction

    function automatic logic mis_f(input logic [5:0] op, input int k);
        return ((op == LH || op == LHU || op == SH) && (k % 2 == 1)) ||
               ((op == LW || op == SW) && k != 0);
    endfunction

    // Memory-side view: which byte of rt lands in which address lane.
    task automatic m_store(input logic [5:0] op, input int k,
                           input logic [31:0] rt,
                           output logic [3:0] mbe, output logic [31:0] wd);
        mbe = 4'h0;
        wd  = 32'h0;
        case (op)
            SB: begin
                for (int i = 0; i < 4; i++) wd = lp(wd, i, rt[7:0]);
                mbe[3-k] = 1'b1;
            end
            SH: begin
                wd = {rt[15:0], rt[15:0]};
                mbe[3-k] = 1'b1;
                mbe[2-k] = 1'b1;
            end
            SW: begin
                wd  = rt;
                mbe = 4'hf;
            end
            SWL: for (int j = 0; k + j <= 3; j++) begin
                wd = lp(wd, k + j, lg(rt, j));
                mbe[3-k-j] = 1'b1;
            end
            SWR: for (int j = 0; j <= k; j++) begin
                wd = lp(wd, k - j, lg(rt, 3 - j));
                mbe[3-k+j] = 1'b1;
            end
            default: mbe = 4'hf;
        endcase
    endtask

    function automatic logic [31:0] m_load(input logic [5:0] op,
                                           input int k,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = lg(w, k);
        h = {lg(w, k & 2), lg(w, (k & 2) + 1)};
        case (op)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] a, input logic [31:0] e);
        tot_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s[%0d]: got %h expected %h", nm, inst, a, e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                n_stall[i] += int'(stall[i]);
                n_fault[i] += int'(fault[i]);
                n_rv[i]    += int'(rv[i]);
                n_rd[i]    += int'(drd[i]);
                n_wr[i]    += int'(dwr[i]);
                if (drd[i] || dwr[i]) begin
                    obs_addr[i] = daddr[i];
                    obs_be[i]   = be[i];
                    obs_wd[i]   = wdata[i];
                end
                if (rv[i]) obs_rv[i] = rdata[i];
                if (chk_en) begin
                    chk("stall", i, {31'b0, stall[i]}, {31'b0, ex[i].stall});
                    chk("fault", i, {31'b0, fault[i]}, {31'b0, ex[i].fault});
                    chk("read_valid", i, {31'b0, rv[i]}, {31'b0, ex[i].rv});
                    chk("data_read", i, {31'b0, drd[i]}, {31'b0, ex[i].rd});
                    chk("data_write", i, {31'b0, dwr[i]}, {31'b0, ex[i].wr});
                    chk("read_data", i, rdata[i], ex[i].rdata);
                    if (ex[i].bus) begin
                        chk("address", i, daddr[i], ex[i].addr);
                        chk("byteenable", i, {28'h0, be[i]}, {28'h0, ex[i].be});
                        if (ex[i].wchk)
                            chk("writedata", i, wdata[i], ex[i].wd);
                    end
                end
            end
            if (lit_seq != lit_done) begin
                chk(lit_nm, 0, lit_a, lit_e);
                lit_done = lit_seq;
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        lit_nm = nm;
        lit_a  = a;
        lit_e  = e;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rw,
                          input int nwait, input logic act,
                          input int rst_at, input logic wr_pre);
        int k, len, dmin, dmax;
        int bb [2], dd [2], lim [2];
        logic ld, st, mis, acc;
        logic to [2];
        logic [3:0] mbe;
        logic [31:0] wd, res;
        lim[0] = LIM0;
        lim[1] = LIM1;
        k   = int'(addr[1:0]);
        ld  = is_ld_f(op);
        st  = is_st_f(op);
        mis = (ld || st) && mis_f(op, k);
        acc = act && (ld || st) && !mis;
        m_store(op, k, rt, mbe, wd);
        res = m_load(op, k, rw);
        for (int i = 0; i < 2; i++) begin
            to[i] = acc && lim[i] != 0 && nwait >= lim[i];
            bb[i] = to[i] ? lim[i] : nwait + 1;
            dd[i] = bb[i] + 1;
        end
        dmin = (dd[0] < dd[1]) ? dd[0] : dd[1];
        dmax = (dd[0] > dd[1]) ? dd[0] : dd[1];
        len  = acc ? dmax + 2 : 2;
        if (rst_at >= 0) len = rst_at + 2;
        for (int t = 0; t < len; t++) begin
            @(posedge clk);
            #1;
            reset  = (t == rst_at);
            active = act;
            instruction = ((t == 0 || (acc && t <= dmin)) &&
                           (rst_at < 0 || t < rst_at)) ?
                          {op, 26'h155aa5} : 32'h0;
            mem_address      = addr;
            store_data       = rt;
            data_readdata    = rw;
            data_waitrequest = (t == 0) ? wr_pre : (t <= nwait);
            for (int i = 0; i < 2; i++) begin
                ex[i] = '{default: '0};
                if (rst_at >= 0 && t >= rst_at) begin
                    if (t > rst_at) last_rd[i] = 32'h0;
                end else if (t == 0) begin
                    ex[i].stall = acc;
                    ex[i].fault = act && (ld || st) && mis;
                end else if (acc && t <= bb[i]) begin
                    ex[i].stall = 1'b1;
                    ex[i].rd    = ld;
                    ex[i].wr    = st;
                    ex[i].bus   = 1'b1;
                    ex[i].wchk  = st;
                    ex[i].addr  = {addr[31:2], 2'b00};
                    ex[i].be    = mbe;
                    ex[i].wd    = wd;
                end else if (acc && t == dd[i]) begin
                    ex[i].fault = to[i];
                    ex[i].rv    = ld && !to[i];
                    if (ld && !to[i]) last_rd[i] = res;
                end
                ex[i].rdata = last_rd[i];
            end
        end
    endtask

    logic [5:0] ops [14];
    int s_st, s_rd, s_wr, s_f, s_rv, s1_f, s1_rv;

    task automatic snap();
        s_st  = n_stall[0];
        s_rd  = n_rd[0];
        s_wr  = n_wr[0];
        s_f   = n_fault[0];
        s_rv  = n_rv[0];
        s1_f  = n_fault[1];
        s1_rv = n_rv[1];
    endtask

    initial begin
        ops = '{LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SWL, SW, SWR,
                6'b000000, 6'b001000};
        for (int i = 0; i < 2; i++) begin
            ex[i] = '{default: '0};
            last_rd[i] = 32'h0;
            n_stall[i] = 0; n_fault[i] = 0; n_rv[i] = 0;
            n_rd[i] = 0; n_wr[i] = 0;
            obs_addr[i] = 32'h0; obs_wd[i] = 32'h0;
            obs_rv[i] = 32'h0; obs_be[i] = 4'h0;
        end
        reset = 1'b1;
        active = 1'b0;
        instruction = 32'h0;
        mem_address = 32'h0;
        store_data = 32'h0;
        data_readdata = 32'h0;
        data_waitrequest = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        snap();
        run_op(LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1, -1, 1'b0);
        lit("lw_addr", obs_addr[0], 32'h100);
        lit("lw_be", {28'h0, obs_be[0]}, 32'hF);
        lit("lw_read_cycles", n_rd[0] - s_rd, 1);
        lit("lw_stall_cycles", n_stall[0] - s_st, 2);
        lit("lw_data", obs_rv[0], 32'hDEADBEEF);
        lit("lw_valid_count", n_rv[0] - s_rv, 1);

        run_op(LB, 32'h203, 32'h0, 32'h123456F0, 0, 1'b1, -1, 1'b0);
        lit("lb", obs_rv[0], 32'hFFFFFFF0);
        run_op(LBU, 32'h203, 32'h0, 32'h123456F0, 0, 1'b1, -1, 1'b0);
        lit("lbu", obs_rv[0], 32'h000000F0);
        run_op(LH, 32'h202, 32'h0, 32'h12348001, 0, 1'b1, -1, 1'b0);
        lit("lh", obs_rv[0], 32'hFFFF8001);

        run_op(SB, 32'h301, 32'hAB, 32'h0, 0, 1'b1, -1, 1'b0);
        lit("sb_addr", obs_addr[0], 32'h300);
        lit("sb_be", {28'h0, obs_be[0]}, 32'h4);
        lit("sb_wd", obs_wd[0], 32'hABABABAB);
        run_op(SWL, 32'h302, 32'h11223344, 32'h0, 1, 1'b1, -1, 1'b0);
        lit("swl_be", {28'h0, obs_be[0]}, 32'h3);
        lit("swl_wd", obs_wd[0], 32'h00001122);
        run_op(SWR, 32'h301, 32'h11223344, 32'h0, 0, 1'b1, -1, 1'b0);
        lit("swr_be", {28'h0, obs_be[0]}, 32'hC);
        lit("swr_wd", obs_wd[0], 32'h33440000);

        snap();
        run_op(SW, 32'h405, 32'h55, 32'h0, 0, 1'b1, -1, 1'b0);
        lit("sw_mis_fault", n_fault[0] - s_f, 1);
        lit("sw_mis_write", n_wr[0] - s_wr, 0);
        lit("sw_mis_stall", n_stall[0] - s_st, 0);
        run_op(LWL, 32'h405, 32'h0, 32'hA1B2C3D4, 0, 1'b1, -1, 1'b0);
        lit("lwl_addr", obs_addr[0], 32'h404);

        snap();
        run_op(LW, 32'h600, 32'h0, 32'h0BADCAFE, 4, 1'b1, -1, 1'b1);
        lit("wait_stall_cycles", n_stall[0] - s_st, 6);
        lit("wait_data", obs_rv[0], 32'h0BADCAFE);
        lit("lim3_fault", n_fault[1] - s1_f, 1);
        lit("lim3_no_valid", n_rv[1] - s1_rv, 0);

        run_op(LW, 32'h500, 32'h0, 32'hCAFEF00D, 3, 1'b1, 2, 1'b0);
        lit("reset_read_data", rdata[0], 32'h0);
        snap();
        run_op(LW, 32'h700, 32'h0, 32'h13579BDF, 0, 1'b1, -1, 1'b0);
        lit("after_reset_lw", obs_rv[0], 32'h13579BDF);
        lit("after_reset_valid", n_rv[0] - s_rv, 1);

        snap();
        run_op(LW, 32'h800, 32'h0, 32'h1, 0, 1'b0, -1, 1'b0);
        lit("inactive_no_read", n_rd[0] - s_rd, 0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int nw;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            nw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4)
                                             : $urandom_range(0, 1);
            run_op(ops[$urandom_range(0, 13)], a, $urandom, $urandom, nw,
                   $urandom_range(0, 9) != 0, -1,
                   1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Load/store access stage sitting between execute and the load-merge/writeback stage of the Harvard MIPS core.
- Decodes the memory opcode and checks alignment. Runs a handshake with the data memory (read/write plus waitrequest), generating word address, byte enables and lane-shifted store data.
- For loads, returns either the raw word (LW/LWL/LWR, merged downstream) or the sign/zero-extended byte/half (LB/LBU/LH/LHU).
- Stalls the pipeline while a bus access is outstanding.

Parameters:
- WAIT_LIMIT, 255, maximum waitrequest cycles before the access is abandoned with fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- active  in  1  core running; when low, no new access is accepted
- instruction  in  32  current instruction; opcode in [31:26]
- mem_address  in  32  effective byte address (rs + imm)
- store_data  in  32  rt value for stores
- stall  out  1  hold upstream pipeline
- fault  out  1  one-cycle pulse on misalignment or timeout
- read_valid  out  1  one-cycle pulse when read_data is valid for a load
- read_data  out  32  load result to the merge stage
- data_address  out  32  word-aligned address, low two bits always 00
- data_read  out  1  memory read strobe
- data_write  out  1  memory write strobe
- data_byteenable  out  4  bit3 = bits[31:24] = byte offset 0 (big-endian)
- data_writedata  out  32  lane-aligned store data
- data_readdata  in  32  memory read word
- data_waitrequest  in  1  memory not ready; request is held

Behaviour:
- Opcodes:
  - Loads: LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110.
  - Stores: SB 101000, SH 101001, SWL 101010, SW 101011, SWR 101110.
  - Any other opcode is a non-memory op.
- Alignment faults: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. LWL/LWR/SWL/SWR and byte ops never fault.
- FSM states are IDLE, BUS, DONE. Reset forces IDLE, clears the wait counter, and drives all outputs to 0, including while in BUS; the aborted access is simply dropped.
- IDLE:
  - Memory op, active=1, no fault: stall=1 combinationally. Register address, byte enables, write data, opcode and offset, then go to BUS.
  - Memory op with fault: fault=1 and stall=0 this cycle, no bus access, stay in IDLE.
  - Non-memory op or active=0: no action, stall=0.
- BUS:
  - stall=1; data_read or data_write held high with stable address, byte enables and data.
  - waitrequest=0: capture data_readdata (loads) and go to DONE.
  - waitrequest=1: increment the wait counter. If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT, drop the strobes, pulse fault in DONE, and skip read_valid.
- DONE:
  - stall=0 and strobes low; the instruction retires at this edge.
  - read_valid=1 for loads (unless timed out); read_data holds the captured result until the next load completes.
  - Always returns to IDLE and never accepts a request in DONE.
- Minimum latency is 3 cycles (accept, BUS, DONE); each waitrequest cycle adds one.
- Store lanes, with k = addr[1:0]:
  - SB: be=1000>>k, data = {4{rt[7:0]}}.
  - SH: be=1100 (k=0) or 0011 (k=2), data = {2{rt[15:0]}}.
  - SW: be=1111, data = rt.
  - SWL: be=1111>>k, data = rt>>(8k).
  - SWR: be=1111<<(3−k) masked to 4 bits, data = rt<<(8(3−k)).
- Load results:
  - LB/LBU: byte = word[31−8k −: 8], sign- or zero-extended.
  - LH/LHU: half = k=0 ? [31:16] : [15:0], extended.
  - LW/LWL/LWR: raw word; LWL/LWR merging is done downstream using reg_d.
- For loads, data_byteenable = 1111.

Decomposition:
- Shared package mips_mem_pkg holds the opcode localparams, the state enum (IDLE/BUS/DONE), and functions for byte-enable and store-lane generation.
- One natural sub-module, load_extend: combinational byte/half extraction and sign extension from the captured word, opcode and offset.

Test Plan:
- LW at 0x100, waitrequest=0, readdata=0xDEADBEEF:
  - data_address=0x100, data_read high for 1 cycle, be=1111.
  - read_valid in the 3rd cycle, read_data=0xDEADBEEF.
  - stall high for exactly 2 cycles.
- LB at 0x203 with readdata=0x123456F0 → read_data=0xFFFFFFF0; LBU same → 0x000000F0; LH at 0x202 with 0x1234_8001 → 0xFFFF8001.
- SB at 0x301, rt=0xAB → be=0100, writedata=0xABABABAB, address 0x300. SWL at 0x302, rt=0x11223344 → be=0011, writedata=0x00001122. SWR at 0x301, rt=0x11223344 → be=1100, writedata=0x33440000.
- SW at 0x405 → fault pulse, no data_write, stall never asserted. LWL at 0x405 → normal access at 0x404.
- waitrequest held 5 cycles on LW → strobes and address stable throughout, stall held 6 cycles. With WAIT_LIMIT=3: fault in DONE, no read_valid.
- reset asserted during BUS → next cycle IDLE with strobes, stall, read_valid and fault all 0. A following LW completes normally.
